// File: rtl/instr_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue_if
//   Bundles the fetch-stage signals of instr_prefetch_queue: the instruction
//   memory request/response bus, the redirect/stall controls from the branch
//   and hazard units, and the head-of-queue outputs feeding IF/ID.
//
//   master : the prefetch queue itself
//            drives imem_addr, imem_req, out_valid, out_pc, out_instr
//            samples imem_rdata, redirect, redirect_pc, stall
//   slave  : the surrounding pipeline / instruction memory (mirror image)
//
// Parameters
//   PC_W   fetch PC / instruction memory byte-address width
//   INS_W  instruction width
// -----------------------------------------------------------------------------
interface instr_prefetch_queue_if #(
   parameter int PC_W  = 9,
   parameter int INS_W = 32
);

   // instruction memory bus
   logic [PC_W-1:0]  imem_addr;
   logic             imem_req;
   logic [INS_W-1:0] imem_rdata;

   // pipeline control
   logic             redirect;
   logic [PC_W-1:0]  redirect_pc;
   logic             stall;

   // head of queue towards IF/ID
   logic             out_valid;
   logic [PC_W-1:0]  out_pc;
   logic [INS_W-1:0] out_instr;

   modport master (
      output imem_addr,
      output imem_req,
      input  imem_rdata,
      input  redirect,
      input  redirect_pc,
      input  stall,
      output out_valid,
      output out_pc,
      output out_instr
   );

   modport slave (
      input  imem_addr,
      input  imem_req,
      output imem_rdata,
      output redirect,
      output redirect_pc,
      output stall,
      input  out_valid,
      input  out_pc,
      input  out_instr
   );

endinterface : instr_prefetch_queue_if

// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
//   Fetch stage sitting in front of the IF/ID register. Owns the fetch PC,
//   issues sequential requests to a synchronous instruction memory (one-cycle
//   read latency), buffers returned {pc, instr} pairs in a small FIFO and
//   presents the head entry to IF/ID. Hazard stalls are absorbed without
//   refetching; a redirect flushes the FIFO, kills any in-flight response and
//   restarts fetch at redirect_pc.
//
// Parameters
//   PC_W   fetch PC / byte-address width            (default 9)
//   INS_W  instruction width                        (default 32)
//   DEPTH  FIFO entries, 2..16; >=3 sustains 1/cycle (default 4)
//
// Ports
//   clk        in   clock, all state updates on posedge
//   reset      in   synchronous, active-high
//   bus        master modport of instr_prefetch_queue_if:
//                imem_addr/imem_req out, imem_rdata in   (instruction memory)
//                redirect/redirect_pc/stall in           (branch + hazard units)
//                out_valid/out_pc/out_instr out          (head entry to IF/ID)
//   occupancy  out  entries currently held in the FIFO
//
// Build option
//   PREFETCH_BYPASS_EN  when defined, a live response arriving at an empty
//                       FIFO is presented on the outputs in the same cycle
//                       (consumed directly unless stalled). When undefined the
//                       outputs come from FIFO storage only.
// -----------------------------------------------------------------------------
module instr_prefetch_queue #(
   parameter int PC_W  = 9,
   parameter int INS_W = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   instr_prefetch_queue_if.master       bus,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W:0]   DEPTH_CNT = (OCC_W + 1)'(DEPTH);

   // fetch PC: address of the next request
   logic [PC_W-1:0]  fpc;

   // A request was issued last cycle and its response (on imem_rdata this
   // cycle) is still wanted. A redirect clears it, which is how an in-flight
   // response gets killed: the memory still returns data but nobody takes it.
   logic             rsp_live;
   logic [PC_W-1:0]  rsp_pc;

   // FIFO storage and bookkeeping
   logic [PC_W-1:0]  mem_pc    [DEPTH];
   logic [INS_W-1:0] mem_instr [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [OCC_W-1:0] count;

   // per-cycle decisions
   logic             fifo_empty;
   logic             issue;
   logic             push;
   logic             pop;
   logic             head_valid;
   logic [PC_W-1:0]  head_pc;
   logic [INS_W-1:0] head_instr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // -------------------------------------------------------------------------
   // Issue, push/pop and head selection
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      fifo_empty = (count == '0);

      // The in-flight response already owns a slot, so counting it here
      // guarantees the FIFO can never overflow. A pop in the same cycle is
      // deliberately not credited; DEPTH>=3 still keeps one request per cycle.
      issue = !reset && !bus.redirect &&
              (({1'b0, count} + {{OCC_W{1'b0}}, rsp_live}) < DEPTH_CNT);

      push       = rsp_live;
      pop        = !fifo_empty && !bus.stall;
      head_valid = !fifo_empty;
      head_pc    = '0;
      head_instr = '0;

      if (!fifo_empty) begin
         head_pc    = mem_pc[rd_ptr];
         head_instr = mem_instr[rd_ptr];
      end
`ifdef PREFETCH_BYPASS_EN
      else if (rsp_live) begin
         // Empty FIFO: hand the response straight to IF/ID. It only needs
         // storing if IF/ID is stalled and cannot take it this cycle.
         head_valid = 1'b1;
         head_pc    = rsp_pc;
         head_instr = bus.imem_rdata;
         push       = bus.stall;
      end
`endif
   end

   assign bus.imem_addr = fpc;
   assign bus.imem_req  = issue;
   assign bus.out_valid = head_valid;
   assign bus.out_pc    = head_pc;
   assign bus.out_instr = head_instr;
   assign occupancy     = count;

   // -------------------------------------------------------------------------
   // Control state. Reset beats redirect, redirect beats push/pop/issue.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         fpc      <= '0;
         rsp_live <= 1'b0;
         rsp_pc   <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (bus.redirect) begin
         // No request goes out in a redirect cycle, so the new stream starts
         // cleanly at redirect_pc next cycle. No alignment is enforced.
         fpc      <= bus.redirect_pc;
         rsp_live <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (issue) begin
            fpc <= fpc + PC_W'(4);   // wraps modulo 2**PC_W
         end
         rsp_live <= issue;
         rsp_pc   <= fpc;

         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end

         case ({push, pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // FIFO storage
   // -------------------------------------------------------------------------
   // NOTE: the storage array has no reset; validity is carried entirely by
   // count/pointers, and stale contents are never presented as valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr]    <= rsp_pc;
         mem_instr[wr_ptr] <= bus.imem_rdata;
      end
   end

endmodule : instr_prefetch_queue

// File: tb/tb_instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_queue
//   Self-checking bench for instr_prefetch_queue (PC_W=9, INS_W=32, DEPTH=4).
//   A synchronous instruction memory returns addr | 32'hA000_0000 one cycle
//   after each request. A transaction-level reference model (queue of PCs,
//   one pending-response slot, fetch PC) predicts every output each cycle.
//   Directed scenarios cover reset, stall saturation, redirects (including
//   PC wrap and redirect+stall on a full FIFO), reset mid-stream; a random
//   phase follows. Build with +define+PREFETCH_BYPASS_EN for the bypass mode.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_queue;

   localparam int PC_W  = 9;
   localparam int INS_W = 32;
   localparam int DEPTH = 4;
   localparam int OCC_W = $clog2(DEPTH + 1);

`ifdef PREFETCH_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [OCC_W-1:0] occupancy;

   instr_prefetch_queue_if #(.PC_W(PC_W), .INS_W(INS_W)) bus ();

   instr_prefetch_queue #(
      .PC_W  (PC_W),
      .INS_W (INS_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   // synchronous instruction memory, one-cycle read latency
   always @(posedge clk) begin
      if (bus.imem_req) begin
         bus.imem_rdata <= 32'hA000_0000 | {23'b0, bus.imem_addr};
      end
   end

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------- reference model
   logic [PC_W-1:0] m_q[$];       // PCs held in the FIFO, head first
   bit              m_pend;       // a wanted response arrives this cycle
   logic [PC_W-1:0] m_pend_pc;
   logic [PC_W-1:0] m_fpc;

   bit              e_req;
   logic [PC_W-1:0] e_addr;
   bit              e_valid;
   logic [PC_W-1:0] e_pc;

   function automatic void model_eval();
      e_req   = !reset && !bus.redirect && ((m_q.size() + int'(m_pend)) < DEPTH);
      e_addr  = m_fpc;
      e_valid = 1'b0;
      e_pc    = '0;
      if (m_q.size() > 0) begin
         e_valid = 1'b1;
         e_pc    = m_q[0];
      end else if (BYPASS && m_pend) begin
         e_valid = 1'b1;
         e_pc    = m_pend_pc;
      end
   endfunction

   function automatic void model_commit();
      bit taken_direct;
      if (reset) begin
         m_q.delete();
         m_pend = 1'b0;
         m_fpc  = '0;
      end else if (bus.redirect) begin
         m_q.delete();
         m_pend = 1'b0;
         m_fpc  = bus.redirect_pc;
      end else begin
         taken_direct = BYPASS && (m_q.size() == 0) && m_pend && !bus.stall;
         if (m_q.size() > 0 && !bus.stall) void'(m_q.pop_front());
         if (m_pend && !taken_direct) m_q.push_back(m_pend_pc);
         m_pend    = e_req;
         m_pend_pc = m_fpc;
         if (e_req) m_fpc = m_fpc + 9'd4;
      end
   endfunction

   // observed outputs of the most recent step (sampled at negedge)
   logic             o_req;
   logic [PC_W-1:0]  o_addr;
   logic             o_valid;
   logic [PC_W-1:0]  o_pc;
   logic [INS_W-1:0] o_instr;
   logic [OCC_W-1:0] o_occ;

   // One clock cycle: sample and compare mid-cycle, then advance past the edge.
   task automatic step();
      @(negedge clk);
      model_eval();
      o_req   = bus.imem_req;
      o_addr  = bus.imem_addr;
      o_valid = bus.out_valid;
      o_pc    = bus.out_pc;
      o_instr = bus.out_instr;
      o_occ   = occupancy;
      if (reset) begin
         check("req_in_reset", o_req, 0);
      end else begin
         check("imem_req", o_req, e_req);
         check("imem_addr", o_addr, e_addr);
         check("out_valid", o_valid, e_valid);
         if (e_valid) begin
            check("out_pc", o_pc, e_pc);
            check("out_instr", o_instr, 32'hA000_0000 | {23'b0, e_pc});
         end
         check("occupancy", o_occ, m_q.size());
      end
      model_commit();
      @(posedge clk);
      #1;
   endtask

   // Step until the first valid output; reports its PC and whether one came.
   task automatic first_valid(input int budget, output bit got, output logic [PC_W-1:0] pc);
      got = 1'b0;
      pc  = '0;
      for (int i = 0; i < budget && !got; i++) begin
         step();
         if (i == 0) check("occ_after_flush", o_occ, 0);
         if (o_valid) begin
            got = 1'b1;
            pc  = o_pc;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------- stimulus
   initial begin
      bit              found;
      bit              got;
      logic [PC_W-1:0] pc;
      int              max_occ;
      int              idx;
      logic [PC_W-1:0] wrap_seq [4];

      m_pend = 1'b0; m_pend_pc = '0; m_fpc = '0;
      reset = 1'b1;
      bus.redirect = 1'b0;
      bus.redirect_pc = '0;
      bus.stall = 1'b0;
      step();
      step();

      // 1: reset release, free-running stream
      reset = 1'b0;
      step();
      check("rst_out_valid", o_valid, 0);
      check("rst_out_pc", o_pc, 0);
      check("rst_out_instr", o_instr, 0);
      check("rst_occupancy", o_occ, 0);
      check("first_req", o_req, 1);
      check("first_addr", o_addr, 0);
      max_occ = 0;
      found   = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         model_eval();
         if (e_valid && e_pc == 9'h010) found = 1'b1;
         else begin
            step();
            if (int'(o_occ) > max_occ) max_occ = int'(o_occ);
         end
      end
      check("t1_reach_010", found, 1);
      check("t1_occ_le_2", (max_occ <= 2), 1);

      // 2: stall six cycles with head at 0x010, then drain
      bus.stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("t2_hold_valid", o_valid, 1);
         check("t2_hold_pc", o_pc, 9'h010);
      end
      check("t2_full_occ", o_occ, DEPTH);
      check("t2_full_no_req", o_req, 0);
      bus.stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t2_drain_valid", o_valid, 1);
         check("t2_drain_pc", o_pc, 9'h010 + 9'(4 * i));
      end

      // 5: reset mid-stream with occupancy 3
      bus.stall = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (m_q.size() == 3) found = 1'b1;
         else step();
      end
      check("t5_reach_occ3", found, 1);
      reset = 1'b1;
      bus.stall = 1'b0;
      step();
      reset = 1'b0;
      step();
      check("t5_valid_cleared", o_valid, 0);
      check("t5_occ_cleared", o_occ, 0);
      check("t5_refetch_req", o_req, 1);
      check("t5_refetch_addr", o_addr, 0);

      // 3: redirect while the request for 0x020 is in flight
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_pend && m_pend_pc == 9'h020) found = 1'b1;
         else step();
      end
      check("t3_inflight_020", found, 1);
      bus.redirect = 1'b1;
      bus.redirect_pc = 9'h0C0;
      step();
      bus.redirect = 1'b0;
      first_valid(10, got, pc);
      check("t3_got_output", got, 1);
      check("t3_first_pc", pc, 9'h0C0);

      // 4: redirect near the top of the address space, PC wraps
      bus.redirect = 1'b1;
      bus.redirect_pc = 9'h1F8;
      step();
      bus.redirect = 1'b0;
      wrap_seq[0] = 9'h1F8; wrap_seq[1] = 9'h1FC;
      wrap_seq[2] = 9'h000; wrap_seq[3] = 9'h004;
      idx = 0;
      for (int i = 0; i < 12 && idx < 4; i++) begin
         step();
         if (o_valid) begin
            check("t4_wrap_pc", o_pc, wrap_seq[idx]);
            idx++;
         end
      end
      check("t4_wrap_count", idx, 4);

      // 6: redirect and stall together on a full FIFO
      bus.stall = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m_q.size() == DEPTH) found = 1'b1;
         else step();
      end
      check("t6_reach_full", found, 1);
      bus.redirect = 1'b1;
      bus.redirect_pc = 9'h0A4;
      step();
      check("t6_full_before_flush", o_occ, DEPTH);
      bus.redirect = 1'b0;
      bus.stall = 1'b0;
      first_valid(10, got, pc);
      check("t6_got_output", got, 1);
      check("t6_first_pc", pc, 9'h0A4);

      // random traffic: stalls, redirects (unaligned allowed), rare resets
      for (int c = 0; c < 2000; c++) begin
         reset           = ($urandom_range(0, 199) == 0);
         bus.redirect    = ($urandom_range(0, 29) == 0);
         bus.redirect_pc = 9'($urandom_range(0, 511));
         bus.stall       = ($urandom_range(0, 99) < 35);
         step();
      end
      reset = 1'b0;
      bus.redirect = 1'b0;
      bus.stall = 1'b0;
      for (int i = 0; i < 8; i++) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_instr_prefetch_queue
